// File: rtl/conv_window_feeder.sv
// conv_window_feeder: buffers KERNEL_SIZE image rows per input channel and
// streams sliding-window vectors plus one bias vector to the conv array.
//
// Optional feature macro: CONV_WIN_ZERO_PAD_EN. When defined, each buffered
// row is presented as {0, row, 0} and ARRAY_SIZE must be IMAGE_SIZE-KERNEL_SIZE+3.
// Otherwise ARRAY_SIZE must be IMAGE_SIZE-KERNEL_SIZE+1.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   enable        block enable; low forces IDLE and clears counters/data_out
//   cmd           0=IDLE 1=SHIFT 2=LOAD 3=reserved (treated as IDLE)
//   data_in       external read data, one cycle after ext_rom_addr
//   ack           1-cycle pulse: 1=SHIFT_FIN 2=LOAD_FIN 3=ERR
//   ext_rom_addr  external read address (wraps)
//   data_out      window vector, lane 0 at MSBs
//   data_valid    data_out holds a window or bias vector
module conv_window_feeder #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned KERNEL_SIZE = 3,
    parameter int unsigned IMAGE_SIZE  = 8,
`ifdef CONV_WIN_ZERO_PAD_EN
    parameter int unsigned ARRAY_SIZE  = 8,
`else
    parameter int unsigned ARRAY_SIZE  = 6,
`endif
    parameter int unsigned CHANNELS    = 2,
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter logic [DATA_WIDTH-1:0] BIAS_VALUE = DATA_WIDTH'(32'h3F800000)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           enable,
    input  logic [1:0]                     cmd,
    input  logic [DATA_WIDTH-1:0]          data_in,
    output logic [1:0]                     ack,
    output logic [ADDR_WIDTH-1:0]          ext_rom_addr,
    output logic [ARRAY_SIZE*DATA_WIDTH-1:0] data_out,
    output logic                           data_valid
);

`ifdef CONV_WIN_ZERO_PAD_EN
    localparam int unsigned PAD = 1;
`else
    localparam int unsigned PAD = 0;
`endif
    localparam int unsigned PW   = IMAGE_SIZE + 2 * PAD;
    localparam int unsigned NW   = CHANNELS * IMAGE_SIZE;
    localparam int unsigned CW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned RW   = $clog2(KERNEL_SIZE);
    localparam int unsigned RW1  = RW + 1;
    localparam int unsigned COLW = $clog2(IMAGE_SIZE);
    localparam int unsigned LCW  = $clog2(NW + 1);
    localparam int unsigned RLW  = $clog2(KERNEL_SIZE + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_BIAS  = 2'd3;

    localparam logic [1:0] CMD_SHIFT = 2'd1;
    localparam logic [1:0] CMD_LOAD  = 2'd2;

    localparam logic [1:0] ACK_IDLE      = 2'd0;
    localparam logic [1:0] ACK_SHIFT_FIN = 2'd1;
    localparam logic [1:0] ACK_LOAD_FIN  = 2'd2;
    localparam logic [1:0] ACK_ERR       = 2'd3;

    logic [1:0]                 state_q, state_d;
    logic [1:0]                 ack_q, ack_d;
    logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
    logic [LCW-1:0]             cnt_q, cnt_d;
    logic [CW-1:0]              wch_q, wch_d;
    logic [COLW-1:0]            wcol_q, wcol_d;
    logic [CW-1:0]              ch_q, ch_d;
    logic [RW-1:0]              row_q, row_d;
    logic [RW-1:0]              sh_q, sh_d;
    logic [RW-1:0]              wr_row_q, wr_row_d;
    logic [RLW-1:0]             rows_q, rows_d;
    logic [PW*DATA_WIDTH-1:0]   sr_q, sr_d;
    logic                       valid_q, valid_d;
    logic                       wr_en_c;

    logic [DATA_WIDTH-1:0]      buf_q [CHANNELS][KERNEL_SIZE][IMAGE_SIZE];
    logic [RW1-1:0]             row_sum_c;
    logic [RW-1:0]              row_abs_c;
    logic [IMAGE_SIZE*DATA_WIDTH-1:0] row_c;
    logic [PW*DATA_WIDTH-1:0]   padded_c;

    // Next-state, counter and ack logic
    always_comb begin
        state_d  = state_q;
        ack_d    = ACK_IDLE;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        wch_d    = wch_q;
        wcol_d   = wcol_q;
        ch_d     = ch_q;
        row_d    = row_q;
        sh_d     = sh_q;
        wr_row_d = wr_row_q;
        rows_d   = rows_q;
        wr_en_c  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd == CMD_LOAD) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                    wch_d   = '0;
                    wcol_d  = '0;
                end else if (cmd == CMD_SHIFT) begin
                    if (rows_q == RLW'(KERNEL_SIZE)) begin
                        state_d = S_SHIFT;
                        ch_d    = '0;
                        row_d   = '0;
                        sh_d    = '0;
                    end else begin
                        ack_d = ACK_ERR;
                    end
                end
            end
            S_LOAD: begin
                cnt_d = cnt_q + LCW'(1);
                if (cnt_q != LCW'(NW)) addr_d = addr_q + ADDR_WIDTH'(1);
                // data_in lags its address by one cycle, so writes start on count 1
                if (cnt_q != '0) begin
                    wr_en_c = 1'b1;
                    if (wcol_q == COLW'(IMAGE_SIZE - 1)) begin
                        wcol_d = '0;
                        wch_d  = wch_q + CW'(1);
                    end else begin
                        wcol_d = wcol_q + COLW'(1);
                    end
                end
                if (cnt_q == LCW'(NW)) begin
                    state_d  = S_IDLE;
                    ack_d    = ACK_LOAD_FIN;
                    cnt_d    = '0;
                    wr_row_d = (wr_row_q == RW'(KERNEL_SIZE - 1)) ? '0 : wr_row_q + RW'(1);
                    if (rows_q != RLW'(KERNEL_SIZE)) rows_d = rows_q + RLW'(1);
                end
            end
            S_SHIFT: begin
                // Loop order: channel outer, row middle, shift inner
                if (sh_q == RW'(KERNEL_SIZE - 1)) begin
                    sh_d = '0;
                    if (row_q == RW'(KERNEL_SIZE - 1)) begin
                        row_d = '0;
                        if (ch_q == CW'(CHANNELS - 1)) begin
                            ch_d    = '0;
                            state_d = S_BIAS;
                        end else begin
                            ch_d = ch_q + CW'(1);
                        end
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end else begin
                    sh_d = sh_q + RW'(1);
                end
            end
            S_BIAS: begin
                ack_d = ACK_SHIFT_FIN;
                if (cmd == CMD_LOAD) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                    wch_d   = '0;
                    wcol_d  = '0;
                end else if (cmd == CMD_SHIFT) begin
                    state_d = S_SHIFT;
                    ch_d    = '0;
                    row_d   = '0;
                    sh_d    = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Disable keeps buffers, address and row bookkeeping, clears the rest
        if (!enable) begin
            state_d  = S_IDLE;
            ack_d    = ACK_IDLE;
            addr_d   = addr_q;
            cnt_d    = '0;
            wch_d    = '0;
            wcol_d   = '0;
            ch_d     = '0;
            row_d    = '0;
            sh_d     = '0;
            wr_row_d = wr_row_q;
            rows_d   = rows_q;
            wr_en_c  = 1'b0;
        end
    end

    // Window datapath: output register follows the state being entered
    always_comb begin
        row_sum_c = {1'b0, wr_row_q} + {1'b0, row_d};
        if (row_sum_c >= RW1'(KERNEL_SIZE)) row_sum_c = row_sum_c - RW1'(KERNEL_SIZE);
        row_abs_c = row_sum_c[RW-1:0];

        row_c = '0;
        for (int unsigned i = 0; i < IMAGE_SIZE; i++) begin
            row_c[(IMAGE_SIZE-1-i)*DATA_WIDTH +: DATA_WIDTH] = buf_q[ch_d][row_abs_c][i];
        end
`ifdef CONV_WIN_ZERO_PAD_EN
        padded_c = {{DATA_WIDTH{1'b0}}, row_c, {DATA_WIDTH{1'b0}}};
`else
        padded_c = row_c;
`endif

        sr_d    = '0;
        valid_d = 1'b0;
        if (state_d == S_SHIFT) begin
            valid_d = 1'b1;
            if (sh_d == '0) sr_d = padded_c;
            else            sr_d = {sr_q[PW*DATA_WIDTH-DATA_WIDTH-1:0], {DATA_WIDTH{1'b0}}};
        end else if (state_d == S_BIAS) begin
            valid_d = 1'b1;
            sr_d    = {PW{BIAS_VALUE}};
        end
    end

    // Control and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            ack_q    <= ACK_IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            wch_q    <= '0;
            wcol_q   <= '0;
            ch_q     <= '0;
            row_q    <= '0;
            sh_q     <= '0;
            wr_row_q <= '0;
            rows_q   <= '0;
            sr_q     <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            wch_q    <= wch_d;
            wcol_q   <= wcol_d;
            ch_q     <= ch_d;
            row_q    <= row_d;
            sh_q     <= sh_d;
            wr_row_q <= wr_row_d;
            rows_q   <= rows_d;
            sr_q     <= sr_d;
            valid_q  <= valid_d;
        end
    end

    // Line buffers carry no reset
    always_ff @(posedge clk) begin
        if (wr_en_c) buf_q[wch_q][wr_row_q][wcol_q] <= data_in;
    end

    assign ack          = ack_q;
    assign ext_rom_addr = addr_q;
    assign data_out     = sr_q[PW*DATA_WIDTH-1 -: ARRAY_SIZE*DATA_WIDTH];
    assign data_valid   = valid_q;

endmodule
